kmeans_frame_sequencer: RTL and testbench
=========================================

// Module: kmeans_frame_sequencer
// PURPOSE
//  Frame-level controller for the moving-frame k-means centroid tracker.
//  Latches player count per frame, issues tabulate at end of frame, waits (with timeout) for k-means results.
//  Publishes per-player centroids and tracks per-player convergence/lock for downstream game logic.
//  Sits between video timing (frame pulses), the k-means block and the game/overlay logic.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles WAIT holds for km_valid_in after tabulate_out; 2..65535
//  CONVERGE_THRESH 8   max Manhattan move (px) between published frames still counted as stable
//  LOCK_FRAMES     4   consecutive stable frames before locked_out[i] asserts; 1..15
// PORTS
//  clk_in           in   1        system clock
//  rst_in           in   1        synchronous active-high reset
//  new_frame_in     in   1        1-cycle pulse, first pixel of frame
//  frame_done_in    in   1        1-cycle pulse, after last active pixel
//  num_players_in   in   2        requested players minus 1
//  km_valid_in      in   1        k-means valid_out
//  km_x_in          in   [3:0][11] k-means centroid x per player
//  km_y_in          in   [3:0][10] k-means centroid y per player
//  tabulate_out     out  1        to k-means tabulate_in
//  km_num_players_out out 2       to k-means num_players; frame-latched copy
//  km_rst_out       out  1        1-cycle reseed request to k-means, OR'd into its reset
//  x_out            out  [3:0][11] published centroid x
//  y_out            out  [3:0][10] published centroid y
//  valid_out        out  1        1-cycle pulse when x_out/y_out updated
//  locked_out       out  4        per-player lock flag
//  timeout_err_out  out  1        sticky: last WAIT expired
//  frame_skip_out   out  1        1-cycle pulse, frame boundary arrived while busy
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; km_num_players_out=0; stable counters 0; published/prev centroids 0.
//  FSM: IDLE -> RUN -> TAB -> WAIT -> UPDATE -> IDLE.
//   IDLE:   new_frame_in -> RUN; latch num_players_in into km_num_players_out.
//           If latched value != previous latched value: pulse km_rst_out same cycle as RUN entry;
//           clear all stable counters and locked_out.
//           frame_done_in ignored.
//   RUN:    frame_done_in -> TAB. new_frame_in without frame_done_in: stay in RUN, pulse frame_skip_out.
//           Both asserted in same cycle: frame_done_in wins -> TAB; no skip pulse.
//   TAB:    tabulate_out=1 for exactly this cycle (frame_done_in at t -> tabulate_out at t+1).
//           Clear wait counter; -> WAIT.
//   WAIT:   counter increments each cycle.
//           km_valid_in: capture km_x_in/km_y_in for players 0..N (N=km_num_players_out) -> UPDATE.
//           Counter reaches TIMEOUT_CYCLES-1 without km_valid_in: set timeout_err_out, -> IDLE;
//           published outputs unchanged; valid_out not pulsed.
//           km_valid_in on the expiry cycle counts as success.
//           new_frame_in here (and in TAB/UPDATE): pulse frame_skip_out; frame not processed.
//   UPDATE: per active player i, d=|cap_x-x_out[i]|+|cap_y-y_out[i]|.
//           Unsigned compares, no wrap; dx 11b, dy 10b, d 12b.
//           d<=CONVERGE_THRESH: stable[i]++ (saturate at LOCK_FRAMES); else stable[i]=0.
//           locked_out[i] = stable[i]>=LOCK_FRAMES, updated together with x_out.
//           Write x_out/y_out; pulse valid_out; clear timeout_err_out; -> IDLE.
//  Inactive players (i>N): x_out/y_out forced 0, stable 0, locked_out 0.
//  Latency: km_valid_in at cycle v -> x_out/y_out/locked_out/valid_out change at v+2.
//  km_valid_in outside WAIT: ignored.
//  num_players_in changes outside IDLE: ignored until next frame start.
//  rst_in mid-operation: immediate return to reset values next edge; no tabulate_out or valid_out emitted after.
// TESTING
//  T1 reset then N=0: new_frame, frame_done@t
//     -> tabulate_out@t+1 only; km_valid@v with (100,50) -> x_out[0]=100,y_out[0]=50,valid_out@v+2.
//  T2 LOCK_FRAMES=4, THRESH=8, N=1: P1 steps (200,100)->(203,102)->(205,104)->(206,104)->(207,105)
//     -> locked_out[1]=1 after 5th frame.
//     Then jump to (300,100) -> locked_out[1]=0 same cycle as valid_out.
//  T3 no km_valid_in after tabulate, TIMEOUT=64
//     -> timeout_err_out=1 at 64th WAIT cycle, IDLE, x_out unchanged.
//     Next good frame clears it.
//  T4 num_players_in 1->3 mid-RUN -> km_num_players_out stays 1 this frame;
//     next new_frame: =3, km_rst_out 1 cycle, locked_out=0.
//  T5 new_frame_in during WAIT -> frame_skip_out pulse, no extra tabulate_out.
//     new_frame&frame_done same cycle in RUN -> TAB, no skip.
//  T6 rst_in asserted in WAIT then km_valid_in -> no valid_out; all outputs 0.

Source files
------------

// File: rtl/kmeans_frame_sequencer.sv
// Frame-level controller for the k-means centroid tracker: latches player count, issues
// tabulate at frame end, waits with timeout for results, publishes centroids and lock flags.
module kmeans_frame_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES  = 64,
    parameter int unsigned CONVERGE_THRESH = 8,
    parameter int unsigned LOCK_FRAMES     = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             new_frame_in,
    input  logic             frame_done_in,
    input  logic [1:0]       num_players_in,
    input  logic             km_valid_in,
    input  logic [3:0][10:0] km_x_in,
    input  logic [3:0][9:0]  km_y_in,
    output logic             tabulate_out,
    output logic [1:0]       km_num_players_out,
    output logic             km_rst_out,
    output logic [3:0][10:0] x_out,
    output logic [3:0][9:0]  y_out,
    output logic             valid_out,
    output logic [3:0]       locked_out,
    output logic             timeout_err_out,
    output logic             frame_skip_out
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_TAB    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UPDATE = 3'd4
    } state_e;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [11:0] THRESH    = 12'(CONVERGE_THRESH);
    localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);

    function automatic logic [11:0] manhattan(input logic [10:0] ax, input logic [10:0] bx,
                                              input logic [9:0] ay, input logic [9:0] by);
        logic [10:0] dx;
        logic [9:0]  dy;
        dx = (ax >= bx) ? (ax - bx) : (bx - ax);
        dy = (ay >= by) ? (ay - by) : (by - ay);
        return {1'b0, dx} + {2'b00, dy};
    endfunction

    state_e           state_q, state_d;
    logic             tabulate_q, tabulate_d;
    logic [1:0]       np_q, np_d;
    logic             km_rst_q, km_rst_d;
    logic [3:0][10:0] x_q, x_d, cap_x_q, cap_x_d;
    logic [3:0][9:0]  y_q, y_d, cap_y_q, cap_y_d;
    logic             valid_q, valid_d;
    logic [3:0]       locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             skip_q, skip_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic [3:0][3:0]  stable_q, stable_d;
    logic [3:0][11:0] dist_s;

    // Movement of each captured centroid relative to the currently published one
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dist_s[i] = manhattan(cap_x_q[i], x_q[i], cap_y_q[i], y_q[i]);
        end
    end

    // Next-state and next-output computation
    always_comb begin
        state_d    = state_q;
        tabulate_d = 1'b0;
        np_d       = np_q;
        km_rst_d   = 1'b0;
        x_d        = x_q;
        y_d        = y_q;
        cap_x_d    = cap_x_q;
        cap_y_d    = cap_y_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        timeout_d  = timeout_q;
        skip_d     = 1'b0;
        wait_cnt_d = wait_cnt_q;
        stable_d   = stable_q;
        case (state_q)
            ST_IDLE: begin
                if (new_frame_in) begin
                    state_d = ST_RUN;
                    np_d    = num_players_in;
                    if (num_players_in != np_q) begin
                        km_rst_d = 1'b1;
                        stable_d = '0;
                        locked_d = 4'b0000;
                    end else begin
                        km_rst_d = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (frame_done_in) begin
                    state_d    = ST_TAB;
                    tabulate_d = 1'b1;
                end else if (new_frame_in) begin
                    skip_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_TAB: begin
                wait_cnt_d = 16'd0;
                state_d    = ST_WAIT;
                skip_d     = new_frame_in;
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 16'd1;
                skip_d     = new_frame_in;
                // A result arriving on the expiry cycle still wins over the timeout
                if (km_valid_in) begin
                    cap_x_d = km_x_in;
                    cap_y_d = km_y_in;
                    state_d = ST_UPDATE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_UPDATE: begin
                skip_d = new_frame_in;
                for (int i = 0; i < 4; i++) begin
                    if (2'(i) <= np_q) begin
                        x_d[i] = cap_x_q[i];
                        y_d[i] = cap_y_q[i];
                        if (dist_s[i] <= THRESH) begin
                            stable_d[i] = (stable_q[i] >= LOCK_N) ? LOCK_N : (stable_q[i] + 4'd1);
                        end else begin
                            stable_d[i] = 4'd0;
                        end
                        locked_d[i] = (stable_d[i] >= LOCK_N);
                    end else begin
                        x_d[i]      = 11'd0;
                        y_d[i]      = 10'd0;
                        stable_d[i] = 4'd0;
                        locked_d[i] = 1'b0;
                    end
                end
                valid_d   = 1'b1;
                timeout_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            tabulate_q <= 1'b0;
            np_q       <= 2'd0;
            km_rst_q   <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            cap_x_q    <= '0;
            cap_y_q    <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 4'b0000;
            timeout_q  <= 1'b0;
            skip_q     <= 1'b0;
            wait_cnt_q <= 16'd0;
            stable_q   <= '0;
        end else begin
            state_q    <= state_d;
            tabulate_q <= tabulate_d;
            np_q       <= np_d;
            km_rst_q   <= km_rst_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cap_x_q    <= cap_x_d;
            cap_y_q    <= cap_y_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
            skip_q     <= skip_d;
            wait_cnt_q <= wait_cnt_d;
            stable_q   <= stable_d;
        end
    end

    assign tabulate_out       = tabulate_q;
    assign km_num_players_out = np_q;
    assign km_rst_out         = km_rst_q;
    assign x_out              = x_q;
    assign y_out              = y_q;
    assign valid_out          = valid_q;
    assign locked_out         = locked_q;
    assign timeout_err_out    = timeout_q;
    assign frame_skip_out     = skip_q;

endmodule

// File: tb/tb_kmeans_frame_sequencer.sv
// Scoreboard bench for kmeans_frame_sequencer: stimulus queues expected publications,
// a negedge monitor pops and compares them whenever valid_out pulses.
module tb_kmeans_frame_sequencer;
    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic             new_frame_in = 1'b0;
    logic             frame_done_in = 1'b0;
    logic [1:0]       num_players_in = 2'd0;
    logic             km_valid_in = 1'b0;
    logic [3:0][10:0] km_x_in = '0;
    logic [3:0][9:0]  km_y_in = '0;
    logic             tabulate_out;
    logic [1:0]       km_num_players_out;
    logic             km_rst_out;
    logic [3:0][10:0] x_out;
    logic [3:0][9:0]  y_out;
    logic             valid_out;
    logic [3:0]       locked_out;
    logic             timeout_err_out;
    logic             frame_skip_out;

    kmeans_frame_sequencer #(
        .TIMEOUT_CYCLES (64),
        .CONVERGE_THRESH(8),
        .LOCK_FRAMES    (4)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .new_frame_in      (new_frame_in),
        .frame_done_in     (frame_done_in),
        .num_players_in    (num_players_in),
        .km_valid_in       (km_valid_in),
        .km_x_in           (km_x_in),
        .km_y_in           (km_y_in),
        .tabulate_out      (tabulate_out),
        .km_num_players_out(km_num_players_out),
        .km_rst_out        (km_rst_out),
        .x_out             (x_out),
        .y_out             (y_out),
        .valid_out         (valid_out),
        .locked_out        (locked_out),
        .timeout_err_out   (timeout_err_out),
        .frame_skip_out    (frame_skip_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0][10:0] x;
        logic [3:0][9:0]  y;
        logic [3:0]       lk;
        int               cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   valid_cnt = 0;
    int   tab_cnt = 0;
    int   tab_cyc = -1;
    int   skip_cnt = 0;
    int   kmrst_cnt = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on each publication, count control pulses
    always @(negedge clk_in) begin
        if (valid_out) begin
            valid_cnt++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got valid_out=1 expected no publication (cycle %0d)", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("x_out", 64'(x_out), 64'(mon_e.x));
                check("y_out", 64'(y_out), 64'(mon_e.y));
                check("locked_out", 64'(locked_out), 64'(mon_e.lk));
                check("valid_latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
        if (tabulate_out) begin
            tab_cnt++;
            tab_cyc = cyc;
        end
        if (frame_skip_out) skip_cnt++;
        if (km_rst_out) kmrst_cnt++;
    end

    function automatic logic [3:0][10:0] mkx(input int a0, input int a1, input int a2, input int a3);
        return {11'(a3), 11'(a2), 11'(a1), 11'(a0)};
    endfunction

    function automatic logic [3:0][9:0] mky(input int a0, input int a1, input int a2, input int a3);
        return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic start_frame(input logic [1:0] np);
        num_players_in = np;
        new_frame_in   = 1'b1;
        tick(1);
        new_frame_in   = 1'b0;
    endtask

    task automatic end_frame();
        int f;
        f = cyc;
        frame_done_in = 1'b1;
        tick(1);
        frame_done_in = 1'b0;
        tick(1);
        check("tabulate_latency", 64'(tab_cyc), 64'(f + 1));
    endtask

    task automatic give_result(input logic [1:0] n, input logic [3:0][10:0] kx,
                               input logic [3:0][9:0] ky, input logic [3:0] lk);
        exp_t e;
        int   vc0;
        int   k;
        for (int i = 0; i < 4; i++) begin
            e.x[i] = (i <= int'(n)) ? kx[i] : 11'd0;
            e.y[i] = (i <= int'(n)) ? ky[i] : 10'd0;
        end
        e.lk  = lk;
        e.cyc = cyc + 2;
        sb_q.push_back(e);
        vc0 = valid_cnt;
        km_x_in     = kx;
        km_y_in     = ky;
        km_valid_in = 1'b1;
        tick(1);
        km_valid_in = 1'b0;
        k = 0;
        while (valid_cnt == vc0 && k < 20) begin
            tick(1);
            k++;
        end
        check("valid_seen", 64'(valid_cnt), 64'(vc0 + 1));
    endtask

    task automatic run_frame(input logic [1:0] n, input logic [3:0][10:0] kx,
                             input logic [3:0][9:0] ky, input logic [3:0] lk);
        start_frame(n);
        tick(2);
        end_frame();
        tick(2);
        give_result(n, kx, ky, lk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int t0, s0, v0, kr0, tcyc, k;

        // T1: reset state, then single-player frame
        rst_in = 1'b1;
        tick(3);
        rst_in = 1'b0;
        tick(1);
        check("rst_x_out", 64'(x_out), 64'd0);
        check("rst_y_out", 64'(y_out), 64'd0);
        check("rst_outputs", 64'({tabulate_out, km_num_players_out, km_rst_out, valid_out,
                                  locked_out, timeout_err_out, frame_skip_out}), 64'd0);
        t0 = tab_cnt;
        run_frame(2'd0, mkx(100, 999, 999, 999), mky(50, 999, 999, 999), 4'b0000);
        tick(2);
        check("t1_single_tabulate", 64'(tab_cnt), 64'(t0 + 1));
        check("t1_no_km_rst", 64'(kmrst_cnt), 64'd0);

        // T2: two players, player 1 converging and locking, then jumping away
        run_frame(2'd1, mkx(100, 200, 0, 0), mky(50, 100, 0, 0), 4'b0000);
        run_frame(2'd1, mkx(100, 203, 0, 0), mky(50, 102, 0, 0), 4'b0000);
        run_frame(2'd1, mkx(100, 205, 0, 0), mky(50, 104, 0, 0), 4'b0000);
        run_frame(2'd1, mkx(100, 206, 0, 0), mky(50, 104, 0, 0), 4'b0001);
        run_frame(2'd1, mkx(100, 207, 0, 0), mky(50, 105, 0, 0), 4'b0011);
        run_frame(2'd1, mkx(100, 300, 0, 0), mky(50, 100, 0, 0), 4'b0001);
        check("t2_km_rst_once", 64'(kmrst_cnt), 64'd1);

        // T3: timeout with no result, stray result ignored, recovery frame
        v0 = valid_cnt;
        start_frame(2'd1);
        tick(2);
        end_frame();
        k = 0;
        while (!timeout_err_out && k < 100) begin
            tick(1);
            k++;
        end
        tcyc = cyc;
        check("t3_timeout_set", 64'(timeout_err_out), 64'd1);
        check("t3_timeout_delay", 64'((tcyc - tab_cyc == 64) || (tcyc - tab_cyc == 65)), 64'd1);
        km_valid_in = 1'b1;
        tick(1);
        km_valid_in = 1'b0;
        tick(3);
        check("t3_no_valid", 64'(valid_cnt), 64'(v0));
        check("t3_x_kept", 64'(x_out), 64'(mkx(100, 300, 0, 0)));
        check("t3_timeout_sticky", 64'(timeout_err_out), 64'd1);
        run_frame(2'd1, mkx(100, 300, 0, 0), mky(50, 100, 0, 0), 4'b0001);
        check("t3_timeout_cleared", 64'(timeout_err_out), 64'd0);

        // T4: player-count change mid-frame takes effect next frame
        start_frame(2'd1);
        tick(1);
        num_players_in = 2'd3;
        tick(1);
        check("t4_np_held", 64'(km_num_players_out), 64'd1);
        end_frame();
        tick(2);
        give_result(2'd1, mkx(100, 300, 50, 70), mky(50, 100, 60, 80), 4'b0001);
        kr0 = kmrst_cnt;
        start_frame(2'd3);
        tick(1);
        check("t4_np_new", 64'(km_num_players_out), 64'd3);
        check("t4_km_rst", 64'(kmrst_cnt), 64'(kr0 + 1));
        check("t4_lock_cleared", 64'(locked_out), 64'd0);
        tick(1);
        end_frame();
        tick(2);
        give_result(2'd3, mkx(100, 300, 50, 70), mky(50, 100, 60, 80), 4'b0000);
        check("t4_km_rst_single", 64'(kmrst_cnt), 64'(kr0 + 1));

        // T5: skips in RUN and WAIT, simultaneous new_frame/frame_done goes to TAB
        s0 = skip_cnt;
        t0 = tab_cnt;
        start_frame(2'd3);
        new_frame_in = 1'b1;
        tick(1);
        new_frame_in = 1'b0;
        tick(1);
        new_frame_in  = 1'b1;
        frame_done_in = 1'b1;
        tick(1);
        new_frame_in  = 1'b0;
        frame_done_in = 1'b0;
        tick(2);
        new_frame_in = 1'b1;
        tick(1);
        new_frame_in = 1'b0;
        tick(1);
        give_result(2'd3, mkx(100, 300, 50, 70), mky(50, 100, 60, 80), 4'b0000);
        tick(2);
        check("t5_skip_count", 64'(skip_cnt), 64'(s0 + 2));
        check("t5_tab_count", 64'(tab_cnt), 64'(t0 + 1));

        // T6: reset during WAIT, late result must not publish
        v0 = valid_cnt;
        start_frame(2'd3);
        tick(2);
        end_frame();
        tick(2);
        rst_in = 1'b1;
        tick(1);
        rst_in = 1'b0;
        km_x_in     = mkx(11, 22, 33, 44);
        km_y_in     = mky(11, 22, 33, 44);
        km_valid_in = 1'b1;
        tick(1);
        km_valid_in = 1'b0;
        tick(4);
        check("t6_no_valid", 64'(valid_cnt), 64'(v0));
        check("t6_x_zero", 64'(x_out), 64'd0);
        check("t6_y_zero", 64'(y_out), 64'd0);
        check("t6_outputs_zero", 64'({tabulate_out, km_num_players_out, km_rst_out, valid_out,
                                      locked_out, timeout_err_out, frame_skip_out}), 64'd0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
